mem_access_unit: RTL and testbench

MEM-stage data-memory access unit for the RISC-TOY pipeline. It consumes the EX/MEM pipeline-register outputs: control bits, the ALU result used as the address, and the store data. It runs loads and stores against a variable-latency data memory over a req/ack handshake and stalls the upstream pipeline until each access completes. It then presents a registered MEM/WB bundle to the writeback stage.

---
 rtl/risc_toy_pkg.sv | 29 ++
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_toy_pkg.sv
// ----------------------------------------------------------------------------
// risc_toy_pkg
// Shared definitions for the RISC-TOY pipeline back end.
//   mauState_e : state encoding of the MEM-stage access unit
//   DATA_W     : native datapath width
//   REG_ADDR_W : register-file address width
//   memWb_t    : MEM/WB bundle as consumed by the writeback stage
// ----------------------------------------------------------------------------
package risc_toy_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    MAU_IDLE   = 1'b0,
    MAU_ACCESS = 1'b1
  } mauState_e;

  typedef struct packed {
    logic                  valid;
    logic                  regWrite;
    logic                  memtoReg;
    logic [REG_ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0]     result;
    logic [DATA_W-1:0]     loadData;
    logic [31:0]           pc;
  } memWb_t;

endpackage

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory access unit. Takes the EX/MEM register outputs, runs
// loads/stores against a variable-latency memory over a REQ/ACK handshake,
// stalls upstream until the access finishes (or times out) and drives the
// registered MEM/WB bundle.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   MemRead_in, MemWrite_in  memory-op control from EX/MEM
//   RegWrite_in, MemtoReg_in writeback control from EX/MEM
//   Write_Addr_in            destination register
//   Result_in                ALU result, also the memory byte address
//   Store_data_in            store data
//   PC_in                    PC+4 of the instruction
//   Stall                    holds EX/MEM and all earlier stages
//   DMEM_REQ/WE/ADDR/WDATA   registered memory request
//   DMEM_RDATA, DMEM_ACK     memory response
//   WB_*                     registered MEM/WB bundle
//   BUS_ERR                  sticky flag, set when an access times out
// ----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic [4:0]        Write_Addr_in,
  input  logic [DATA_W-1:0] Result_in,
  input  logic [DATA_W-1:0] Store_data_in,
  input  logic [31:0]       PC_in,
  output logic              Stall,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [ADDR_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  input  logic              DMEM_ACK,
  output logic              WB_Valid,
  output logic              WB_RegWrite,
  output logic              WB_MemtoReg,
  output logic [4:0]        WB_Write_Addr,
  output logic [DATA_W-1:0] WB_Result,
  output logic [DATA_W-1:0] WB_Load_data,
  output logic [31:0]       WB_PC,
  output logic              BUS_ERR
);

  import risc_toy_pkg::*;

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  mauState_e        state;
  mauState_e        nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             memOp;
  logic             ackDone;
  logic             toHit;
  logic             retire;

  // A read+write request is handled as a write, so WE comes from MemWrite_in.
  assign memOp = MemRead_in | MemWrite_in;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= MAU_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; an ACK on the last allowed cycle wins over the timeout.
  always_comb begin
    nextState = state;
    ackDone   = 1'b0;
    toHit     = 1'b0;
    case (state)
      MAU_IDLE: begin
        if (memOp) begin
          nextState = MAU_ACCESS;
        end
      end
      MAU_ACCESS: begin
        ackDone = DMEM_ACK;
        toHit   = ~DMEM_ACK && (waitCnt == TO_LAST);
        if (DMEM_ACK || toHit) begin
          nextState = MAU_IDLE;
        end
      end
      default: nextState = MAU_IDLE;
    endcase
  end

  // Output logic: stall and the "instruction leaves MEM this edge" strobe.
  always_comb begin
    Stall  = 1'b0;
    retire = 1'b0;
    case (state)
      MAU_IDLE: begin
        Stall  = memOp;
        retire = ~memOp;
      end
      MAU_ACCESS: begin
        Stall  = ~DMEM_ACK && ~toHit;
        retire = DMEM_ACK || toHit;
      end
      default: begin
        Stall  = 1'b0;
        retire = 1'b0;
      end
    endcase
  end

  // Wait counter: cleared on ACCESS entry, counts ACCESS cycles without ACK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      waitCnt <= '0;
    end else if (state == MAU_IDLE && memOp) begin
      waitCnt <= '0;
    end else if (state == MAU_ACCESS && !DMEM_ACK) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  // Memory request register; REQ follows the next state so it never glitches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DMEM_REQ   <= 1'b0;
      DMEM_WE    <= 1'b0;
      DMEM_ADDR  <= '0;
      DMEM_WDATA <= '0;
    end else begin
      DMEM_REQ <= (nextState == MAU_ACCESS);
      if (state == MAU_IDLE && memOp) begin
        DMEM_WE    <= MemWrite_in;
        DMEM_ADDR  <= Result_in[ADDR_W-1:0];
        DMEM_WDATA <= Store_data_in;
      end
    end
  end

  // MEM/WB stage boundary
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WB_Valid      <= 1'b0;
      WB_RegWrite   <= 1'b0;
      WB_MemtoReg   <= 1'b0;
      WB_Write_Addr <= '0;
      WB_Result     <= '0;
      WB_Load_data  <= '0;
      WB_PC         <= '0;
      BUS_ERR       <= 1'b0;
    end else begin
      if (toHit) begin
        BUS_ERR <= 1'b1;
      end
      if (retire) begin
        WB_Valid      <= 1'b1;
        // A timed-out access must not update the register file.
        WB_RegWrite   <= RegWrite_in & ~toHit;
        WB_MemtoReg   <= MemtoReg_in;
        WB_Write_Addr <= Write_Addr_in;
        WB_Result     <= Result_in;
        WB_PC         <= PC_in;
        if (ackDone && !DMEM_WE) begin
          WB_Load_data <= DMEM_RDATA;
        end
      end else begin
        WB_Valid    <= 1'b0;
        WB_RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
// Scoreboard bench: the driver issues instructions, computes the expected
// MEM/WB bundle from the architectural rules and queues it; a monitor pops
// and compares on every WB_Valid. A memory responder serves requests with a
// per-access latency chosen by the driver and checks the request fields.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TO     = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MemRead_in = 1'b0, MemWrite_in = 1'b0, RegWrite_in = 1'b0, MemtoReg_in = 1'b0;
  logic [4:0]  Write_Addr_in = '0;
  logic [31:0] Result_in = '0, Store_data_in = '0, PC_in = '0;
  logic        Stall, DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA;
  logic [31:0] DMEM_RDATA = '0;
  logic        DMEM_ACK = 1'b0;
  logic        WB_Valid, WB_RegWrite, WB_MemtoReg;
  logic [4:0]  WB_Write_Addr;
  logic [31:0] WB_Result, WB_Load_data, WB_PC;
  logic        BUS_ERR;

  always #5 CLK = ~CLK;

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .Write_Addr_in(Write_Addr_in), .Result_in(Result_in),
    .Store_data_in(Store_data_in), .PC_in(PC_in),
    .Stall(Stall), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
    .WB_Write_Addr(WB_Write_Addr), .WB_Result(WB_Result),
    .WB_Load_data(WB_Load_data), .WB_PC(WB_PC), .BUS_ERR(BUS_ERR)
  );

  int nAsserts = 0;
  int nFails   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    nAsserts++;
    nFails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  typedef struct {
    logic        regWrite;
    logic        memtoReg;
    logic [4:0]  wa;
    logic [31:0] result;
    logic [31:0] loadData;
    logic [31:0] pc;
    logic        busErr;
  } wbExp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } acc_t;

  wbExp_t sbQ[$];
  acc_t   accQ[$];
  int     latQ[$];

  logic [31:0] dmem[logic [31:0]];    // the memory the responder serves
  logic [31:0] refMem[logic [31:0]];  // reference model's view of memory
  logic [31:0] refLoad   = '0;
  logic        refBusErr = 1'b0;
  bit          respEnable = 1'b1;
  bit          forceAck   = 1'b0;

  function automatic logic [31:0] initVal(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory responder: ACK in the k-th REQ cycle; random stray ACKs while idle.
  initial begin : responder
    bit   active;
    int   k;
    int   cnt;
    acc_t cur;
    active = 1'b0; k = 1; cnt = 0;
    cur.addr = '0; cur.wdata = '0; cur.we = 1'b0;
    forever begin
      @(negedge CLK);
      if (!respEnable) begin
        active     = 1'b0;
        DMEM_ACK   = forceAck;
        DMEM_RDATA = 32'hBAD0_BAD0;
      end else if (DMEM_REQ) begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          if (latQ.size() > 0) k = latQ.pop_front();
          else begin k = 1; failNow("unexpected_request"); end
          if (accQ.size() > 0) cur = accQ.pop_front();
          else failNow("unexpected_access");
        end
        cnt++;
        check("dmem_addr", DMEM_ADDR, cur.addr);
        check("dmem_we", 32'(DMEM_WE), 32'(cur.we));
        check("dmem_wdata", DMEM_WDATA, cur.wdata);
        if (cnt == k) begin
          DMEM_ACK   = 1'b1;
          DMEM_RDATA = dmem.exists(DMEM_ADDR) ? dmem[DMEM_ADDR] : initVal(DMEM_ADDR);
          if (DMEM_WE) dmem[DMEM_ADDR] = DMEM_WDATA;
        end else begin
          DMEM_ACK   = 1'b0;
          DMEM_RDATA = $urandom;
        end
      end else begin
        active     = 1'b0;
        DMEM_ACK   = ($urandom_range(0, 5) == 0);
        DMEM_RDATA = $urandom;
      end
    end
  end

  // Monitor: every retired instruction must match the head of the scoreboard.
  initial begin : monitor
    wbExp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (WB_Valid === 1'b1) begin
        if (sbQ.size() == 0) begin
          failNow("wb_unexpected_valid");
        end else begin
          e = sbQ.pop_front();
          check("wb_regwrite", 32'(WB_RegWrite), 32'(e.regWrite));
          check("wb_memtoreg", 32'(WB_MemtoReg), 32'(e.memtoReg));
          check("wb_write_addr", 32'(WB_Write_Addr), 32'(e.wa));
          check("wb_result", WB_Result, e.result);
          check("wb_load_data", WB_Load_data, e.loadData);
          check("wb_pc", WB_PC, e.pc);
          check("bus_err", 32'(BUS_ERR), 32'(e.busErr));
        end
      end
    end
  end

  // Presents one instruction, holds it while stalled, queues its expected result.
  // Latency k = REQ cycle in which memory acks; k > TO means it never acks in time.
  task automatic issue(input bit rd, input bit wr, input bit rw, input bit mtr,
                       input logic [4:0] wa, input logic [31:0] res,
                       input logic [31:0] sd, input logic [31:0] pc, input int k);
    bit     isMem;
    bit     tmo;
    int     stalls;
    int     expStalls;
    wbExp_t e;
    acc_t   a;
    isMem = rd | wr;
    tmo   = isMem && (k > TO);
    MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw; MemtoReg_in = mtr;
    Write_Addr_in = wa; Result_in = res; Store_data_in = sd; PC_in = pc;
    if (isMem) begin
      latQ.push_back(k);
      a.addr = res; a.we = wr; a.wdata = sd;
      accQ.push_back(a);
    end
    expStalls = !isMem ? 0 : ((k < TO) ? k : TO);
    if (isMem && !wr && !tmo) refLoad = refMem.exists(res) ? refMem[res] : initVal(res);
    if (isMem && wr && !tmo) refMem[res] = sd;
    refBusErr = refBusErr | tmo;
    e.regWrite = rw & ~tmo;
    e.memtoReg = mtr;
    e.wa       = wa;
    e.result   = res;
    e.loadData = refLoad;
    e.pc       = pc;
    e.busErr   = refBusErr;
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      #2;
      if (Stall) stalls++;
      else break;
    end
    check("stall_cycles", 32'(stalls), 32'(expStalls));
    sbQ.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    acc_t a;
    int   t;
    bit   rd, wr, rw, mtr;
    logic [4:0]  wa;
    logic [31:0] addr;

    // Reset state
    #3;
    check("rst_dmem_req", 32'(DMEM_REQ), 32'd0);
    check("rst_dmem_we", 32'(DMEM_WE), 32'd0);
    check("rst_dmem_addr", DMEM_ADDR, 32'd0);
    check("rst_dmem_wdata", DMEM_WDATA, 32'd0);
    check("rst_wb_valid", 32'(WB_Valid), 32'd0);
    check("rst_wb_result", WB_Result, 32'd0);
    check("rst_wb_load_data", WB_Load_data, 32'd0);
    check("rst_bus_err", 32'(BUS_ERR), 32'd0);
    check("rst_stall_idle", 32'(Stall), 32'd0);
    MemRead_in = 1'b1;
    #1;
    check("rst_stall_memop", 32'(Stall), 32'd1);
    MemRead_in = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b0;

    // Directed cases
    issue(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_1234, 32'h0, 32'h0000_0004, 1);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0008, 2);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0040, 32'h0, 32'h0000_000C, 3);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0080, 32'hA5A5_A5A5, 32'h0000_0010, 1);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0080, 32'h0, 32'h0000_0014, 1);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0000_00C0, 32'h1357_9BDF, 32'h0000_0018, 2);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_00C0, 32'h0, 32'h0000_001C, 1);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_0100, 32'h0, 32'h0000_0020, 10);
    for (int i = 0; i < 10; i++) begin
      issue(1'b0, 1'b0, 1'b1, 1'b0, 5'(i), 32'(i), 32'h0, 32'h100 + 32'(i), 1);
    end
    check("bus_err_sticky", 32'(BUS_ERR), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      t    = $urandom_range(0, 3);
      rd   = (t == 1) || (t == 3);
      wr   = (t >= 2);
      rw   = 1'($urandom_range(0, 1));
      mtr  = 1'($urandom_range(0, 1));
      wa   = 5'($urandom_range(0, 31));
      addr = (t == 0) ? $urandom : (32'($urandom_range(0, 15)) << 2);
      issue(rd, wr, rw, mtr, wa, addr, $urandom, $urandom, $urandom_range(1, 6));
    end

    // Reset in the middle of an access
    MemRead_in = 1'b1; MemWrite_in = 1'b0; RegWrite_in = 1'b1; MemtoReg_in = 1'b1;
    Write_Addr_in = 5'd11; Result_in = 32'h0000_0200; Store_data_in = 32'h0; PC_in = 32'h400;
    latQ.push_back(1000);
    a.addr = 32'h0000_0200; a.we = 1'b0; a.wdata = 32'h0;
    accQ.push_back(a);
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    MemRead_in = 1'b0;
    #1;
    check("arst_dmem_req", 32'(DMEM_REQ), 32'd0);
    check("arst_stall", 32'(Stall), 32'd0);
    check("arst_wb_valid", 32'(WB_Valid), 32'd0);
    check("arst_wb_regwrite", 32'(WB_RegWrite), 32'd0);
    check("arst_wb_memtoreg", 32'(WB_MemtoReg), 32'd0);
    check("arst_wb_write_addr", 32'(WB_Write_Addr), 32'd0);
    check("arst_wb_result", WB_Result, 32'd0);
    check("arst_wb_load_data", WB_Load_data, 32'd0);
    check("arst_wb_pc", WB_PC, 32'd0);
    check("arst_bus_err", 32'(BUS_ERR), 32'd0);
    refLoad    = '0;
    refBusErr  = 1'b0;
    respEnable = 1'b0;
    forceAck   = 1'b1;
    @(posedge CLK);
    #3;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 32'h55 + 32'(i), 32'h0, 32'h500, 1);
    end
    check("late_ack_no_req", 32'(DMEM_REQ), 32'd0);
    forceAck = 1'b0;
    @(negedge CLK);
    #3;
    check("sb_drained", 32'(sbQ.size()), 32'd0);
    check("acc_drained", 32'(accQ.size()), 32'd0);
    check("lat_drained", 32'(latQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
